// File: rtl/parity_arbiter_if.sv
// Requester-side and downstream-side signals of the parity arbiter.
// The arbiter attaches through the slave modport; the environment drives through master.
interface parity_arbiter_if #(
  parameter int N = 4,
  parameter int W = 6
);
  localparam int ID_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [ID_W-1:0] out_id;
  logic [W-1:0]    out_data;
  logic [1:0]      out_par;
  logic [7:0]      err_cnt;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_id, out_data, out_par, err_cnt
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_id, out_data, out_par, err_cnt
  );
endinterface

// File: rtl/parity_arbiter.sv
// Round-robin arbiter feeding a shared parity checker into a one-entry output stage,
// with a saturating count of accepted odd-parity words.
module parity_arbiter #(
  parameter int N = 4,
  parameter int W = 6
) (
  input  logic           clk,
  input  logic           rst,
  parity_arbiter_if.slave bus
);
  localparam int ID_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [W-1:0]    data_q, data_d;
  logic [1:0]      par_q, par_d;
  logic [7:0]      err_q, err_d;

  logic            accept;
  logic            found;
  logic            grant;
  logic [ID_W-1:0] gnt_idx;
  logic [W-1:0]    gnt_word;

  // The stage can take a word when empty or when its current result leaves this cycle.
  assign accept = !rst && (state_q == EMPTY || bus.out_ready);

  // Walk the requesters starting at ptr, wrapping at N, and take the first valid one.
  always_comb begin
    logic [ID_W:0] sum;
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N)) sum = sum - (ID_W+1)'(N);
      if (!found && bus.req_valid[sum[ID_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = sum[ID_W-1:0];
      end
    end
  end

  assign grant    = accept && found;
  assign gnt_word = bus.req_data[gnt_idx*W +: W];

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[gnt_idx] = 1'b1;
  end

  // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    data_d  = data_q;
    par_d   = par_q;
    err_d   = err_q;
    if (grant) begin
      state_d = FULL;
      id_d    = gnt_idx;
      data_d  = gnt_word;
      par_d   = {~^gnt_word, ^gnt_word};
      ptr_d   = (gnt_idx == ID_W'(N-1)) ? '0 : gnt_idx + 1'b1;
      if (^gnt_word && err_q != 8'hFF) err_d = err_q + 8'd1;
    end else if (state_q == FULL && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      par_q   <= 2'b00;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      par_q   <= par_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_id    = id_q;
  assign bus.out_data  = data_q;
  assign bus.out_par   = par_q;
  assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_parity_arbiter.sv
// Bench for parity_arbiter: a cycle model predicts req_ready and held outputs, and a
// scoreboard queue matches each granted word against the result handed off downstream.
module tb_parity_arbiter;
  localparam int N    = 4;
  localparam int W    = 6;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parity_arbiter_if #(.N(N), .W(W)) bus ();
  parity_arbiter #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [W-1:0]    data;
    logic [1:0]      par;
  } res_t;

  res_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, starting at reset values.
  logic            mon_en  = 1'b0;
  logic            m_valid = 1'b0;
  logic [ID_W-1:0] m_id    = '0;
  logic [ID_W-1:0] m_ptr   = '0;
  logic [W-1:0]    m_data  = '0;
  logic [1:0]      m_par   = 2'b00;
  logic [7:0]      m_err   = '0;

  always @(negedge clk) begin
    logic [N-1:0]    v;
    logic [N-1:0]    exp_rdy;
    logic [ID_W-1:0] jj, gi;
    logic            hit;
    logic [W-1:0]    w;
    res_t            e;
    if (mon_en) begin
      v       = bus.req_valid;
      exp_rdy = '0;
      hit     = 1'b0;
      gi      = '0;
      if (!rst && (!m_valid || bus.out_ready)) begin
        for (int k = 0; k < N; k++) begin
          jj = ID_W'((int'(m_ptr) + k) % N);
          if (!hit && v[jj]) begin
            hit = 1'b1;
            gi  = jj;
          end
        end
      end
      if (hit) exp_rdy[gi] = 1'b1;
      check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("out_id",    32'(bus.out_id),    32'(m_id));
      check("out_data",  32'(bus.out_data),  32'(m_data));
      check("out_par",   32'(bus.out_par),   32'(m_par));
      check("err_cnt",   32'(bus.err_cnt),   32'(m_err));

      if (rst) begin
        sb_q.delete();
        m_valid = 1'b0; m_id = '0; m_ptr = '0; m_data = '0; m_par = 2'b00; m_err = '0;
      end else begin
        if (m_valid && bus.out_ready) begin
          check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_id",   32'(bus.out_id),   32'(e.id));
            check("sb_data", 32'(bus.out_data), 32'(e.data));
            check("sb_par",  32'(bus.out_par),  32'(e.par));
          end
          m_valid = 1'b0;
        end
        if (hit) begin
          w = bus.req_data[int'(gi)*W +: W];
          e.id = gi; e.data = w; e.par = {~^w, ^w};
          sb_q.push_back(e);
          m_valid = 1'b1;
          m_id    = gi;
          m_data  = w;
          m_par   = {~^w, ^w};
          m_ptr   = (gi == ID_W'(N-1)) ? '0 : gi + 1'b1;
          if (^w && m_err != 8'hFF) m_err = m_err + 8'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [W-1:0] w);
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = w;
  endtask

  initial begin
    logic [N-1:0] onehot;
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;

    // Reset held two cycles with every requester valid.
    tick();
    mon_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_par",   32'(bus.out_par),   32'd0);
      check("rst_err",   32'(bus.err_cnt),   32'd0);
      if (c == 0) tick();
    end
    rst = 1'b0;
    bus.req_valid = '0;
    #1;
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_err",   32'(bus.err_cnt),   32'd0);

    // Single odd-parity word from requester 0.
    bus.req_valid = 4'b0001;
    bus.req_data[0*W +: W] = 6'b000001;
    bus.out_ready = 1'b1;
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_id",    32'(bus.out_id),    32'd0);
    check("single_data",  32'(bus.out_data),  32'h01);
    check("single_par",   32'(bus.out_par),   32'h1);
    check("single_err",   32'(bus.err_cnt),   32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Round robin with all requesters valid: grants 0,1,2,3,0.
    bus.req_data[0*W +: W] = 6'b000011;
    bus.req_data[1*W +: W] = 6'b000111;
    bus.req_data[2*W +: W] = 6'b001111;
    bus.req_data[3*W +: W] = 6'b011111;
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      onehot = 4'b0001 << (i % N);
      check("rr_ready", 32'(bus.req_ready), 32'(onehot));
      tick();
      check("rr_valid", 32'(bus.out_valid), 32'd1);
      check("rr_par", 32'(bus.out_par), ((i % 2) == 0) ? 32'h2 : 32'h1);
    end
    check("rr_err", 32'(bus.err_cnt), 32'd2);

    // Backpressure for three cycles, then release: requester 1 wins with no bubble.
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_ready", 32'(bus.req_ready), 32'd0);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_id",    32'(bus.out_id),    32'd0);
      check("bp_data",  32'(bus.out_data),  32'h03);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.req_ready), 32'h2);
    tick();
    check("bp_release_valid", 32'(bus.out_valid), 32'd1);
    check("bp_release_id",    32'(bus.out_id),    32'd1);
    check("bp_release_data",  32'(bus.out_data),  32'h07);

    // Mid-operation reset with a held result and ptr at 2.
    bus.out_ready = 1'b0;
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check("mid_rst_id", 32'(bus.out_id), 32'd0);

    // Saturation: 300 odd-parity grants, then one even word.
    set_all(6'b111110);
    repeat (300) tick();
    check("sat_err", 32'(bus.err_cnt), 32'd255);
    set_all(6'b111111);
    tick();
    check("sat_even_par", 32'(bus.out_par), 32'h2);
    check("sat_even_err", 32'(bus.err_cnt), 32'd255);

    bus.req_valid = '0;
    repeat (3) tick();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
